// File: rtl/pipeline_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_pkg
// Shared types and constants for the pipeline hazard/stall controller.
//   state_t      : memory-handshake FSM states (IDLE, WAIT)
//   STALL_*      : bit positions inside the 6-bit stall vector
//   STALL_MEM/ID : canned stall patterns for memory wait and load-use hazards
//   reg_match()  : source-operand vs destination-register compare
// ----------------------------------------------------------------------------
package pipeline_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int STALL_WIDTH  = 6;
    localparam int STALL_PC     = 0;
    localparam int STALL_IF_ID  = 1;
    localparam int STALL_ID_EX  = 2;
    localparam int STALL_EX_MEM = 3;
    localparam int STALL_MEM_WB = 4;
    localparam int STALL_WB     = 5;

    // WB (bit 5) is never held: the oldest instruction always retires.
    localparam logic [STALL_WIDTH-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_WIDTH-1:0] STALL_MEM  = 6'b011111;
    localparam logic [STALL_WIDTH-1:0] STALL_ID   = 6'b000111;

    // True when a real source operand names the given destination register.
    function automatic logic reg_match(input logic [4:0] rs,
                                       input logic       used,
                                       input logic [4:0] rd);
        return used & (rs == rd);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// ----------------------------------------------------------------------------
// mem_wait_timer
// Counts how long the current data-memory access has been outstanding and
// flags when it must be abandoned.
//   clk, rst   : clock, synchronous active-high reset
//   start      : access entering WAIT this cycle (counter loads 1)
//   in_wait    : FSM currently in WAIT
//   ack        : data memory completes the access this cycle
//   timeout    : WAIT cycle in which the counter sits at the limit (comb)
//   mem_err    : registered one-cycle pulse after an abandoned access
// ----------------------------------------------------------------------------
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic in_wait,
    input  logic ack,
    output logic timeout,
    output logic mem_err
);

    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] wait_cnt_d, wait_cnt_q;
    logic                 mem_err_d, mem_err_q;
    logic                 at_limit_s;

    assign at_limit_s = (wait_cnt_q == CNT_LIMIT);
    assign timeout    = in_wait & at_limit_s;
    assign mem_err    = mem_err_q;

    // Next counter value and error pulse; an ack in the limit cycle wins over timeout.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = 1'b0;
        if (in_wait) begin
            if (ack) begin
                wait_cnt_d = CNT_ZERO;
            end else if (at_limit_s) begin
                wait_cnt_d = CNT_ZERO;
                mem_err_d  = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + CNT_ONE;
            end
        end else if (start) begin
            wait_cnt_d = CNT_ONE;
        end else begin
            wait_cnt_d = CNT_ZERO;
        end
    end

    // Counter and error-pulse registers; reset drops any pending error.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= CNT_ZERO;
            mem_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl
// Hazard/stall controller for the 5-stage pipeline.
//   clk, rst                       : clock, synchronous active-high reset
//   mem_read_mem / mem_write_mem   : EX/MEM holds a load / store
//   dmem_ack                       : data memory completes access this cycle
//   mem_read_ex, rd_ex             : ID/EX load and its destination register
//   rs1_id, rs2_id, rs*_used_id    : IF/ID source registers and their validity
//   branch_taken_ex                : EX resolved a taken branch/jump
//   stall[5:0]                     : per-stage hold (PC..WB), combinational
//   flush_if_id, flush_id_ex       : bubble strobes, combinational
//   dmem_req, dmem_we              : memory request and write qualifier
//   mem_err                        : one-cycle pulse on abandoned access
//   stall_cnt                      : cycles with the PC held (wrapping)
// ----------------------------------------------------------------------------
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8,
    parameter int PERF_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read_mem,
    input  logic                  mem_write_mem,
    input  logic                  dmem_ack,
    input  logic                  mem_read_ex,
    input  logic [4:0]            rd_ex,
    input  logic [4:0]            rs1_id,
    input  logic [4:0]            rs2_id,
    input  logic                  rs1_used_id,
    input  logic                  rs2_used_id,
    input  logic                  branch_taken_ex,
    output logic [5:0]            stall,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic                  mem_err,
    output logic [PERF_WIDTH-1:0] stall_cnt
);

    localparam logic [PERF_WIDTH-1:0] PERF_ONE = {{(PERF_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_d, state_q;
    logic                  access_s, req_s, start_s, timeout_s;
    logic                  mem_stall_s, load_use_s;
    logic [5:0]            stall_s;
    logic                  flush_if_id_s, flush_id_ex_s, dmem_req_s, dmem_we_s;
    logic [PERF_WIDTH-1:0] stall_cnt_d, stall_cnt_q;

    // A load and store flagged together are handled as a store.
    assign access_s = mem_read_mem | mem_write_mem;

    mem_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .start   (start_s),
        .in_wait (state_q == WAIT),
        .ack     (dmem_ack),
        .timeout (timeout_s),
        .mem_err (mem_err)
    );

    // Handshake FSM next state and raw request.
    always_comb begin
        state_d = state_q;
        req_s   = 1'b0;
        start_s = 1'b0;
        case (state_q)
            IDLE: begin
                req_s = access_s;
                if (access_s & ~dmem_ack) begin
                    state_d = WAIT;
                    start_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                req_s = 1'b1;
                if (dmem_ack | timeout_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
                req_s   = 1'b0;
            end
        endcase
    end

    // The abandon cycle itself releases the pipeline even though req is still up.
    assign mem_stall_s = req_s & ~dmem_ack & ~timeout_s;
    assign load_use_s  = mem_read_ex & (rd_ex != 5'd0) &
                         (reg_match(rs1_id, rs1_used_id, rd_ex) |
                          reg_match(rs2_id, rs2_used_id, rd_ex));

    // Prioritised stall/flush decode; everything is forced low during reset.
    always_comb begin
        stall_s       = STALL_NONE;
        flush_if_id_s = 1'b0;
        flush_id_ex_s = 1'b0;
        dmem_req_s    = 1'b0;
        dmem_we_s     = 1'b0;
        if (rst) begin
            stall_s = STALL_NONE;
        end else begin
            dmem_req_s = req_s;
            dmem_we_s  = req_s & mem_write_mem;
            if (mem_stall_s) begin
                // Branch/load-use are re-seen once the access completes.
                stall_s = STALL_MEM;
            end else if (load_use_s) begin
                stall_s       = STALL_ID;
                flush_id_ex_s = 1'b1;
                flush_if_id_s = branch_taken_ex;
            end else if (branch_taken_ex) begin
                flush_if_id_s = 1'b1;
                flush_id_ex_s = 1'b1;
            end else begin
                stall_s = STALL_NONE;
            end
        end
    end

    assign stall       = stall_s;
    assign flush_if_id = flush_if_id_s;
    assign flush_id_ex = flush_id_ex_s;
    assign dmem_req    = dmem_req_s;
    assign dmem_we     = dmem_we_s;
    assign stall_cnt   = stall_cnt_q;

    // Performance counter next value, wrapping naturally.
    always_comb begin
        if (stall_s[STALL_PC]) begin
            stall_cnt_d = stall_cnt_q + PERF_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // FSM state and performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            stall_cnt_q <= {PERF_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Table-driven hazard vectors, hand sequences for the memory handshake
// corners, and randomized traffic against a behavioural reference model.
// ----------------------------------------------------------------------------
module tb_pipeline_ctrl;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_mem, mem_write_mem, dmem_ack;
    logic        mem_read_ex;
    logic [4:0]  rd_ex, rs1_id, rs2_id;
    logic        rs1_used_id, rs2_used_id, branch_taken_ex;
    logic [5:0]  stall;
    logic        flush_if_id, flush_id_ex, dmem_req, dmem_we, mem_err;
    logic [31:0] stall_cnt;

    pipeline_ctrl #(.TIMEOUT_CYCLES(T), .CNT_WIDTH(8), .PERF_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem), .dmem_ack(dmem_ack),
        .mem_read_ex(mem_read_ex), .rd_ex(rd_ex), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .branch_taken_ex(branch_taken_ex),
        .stall(stall), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: an outstanding access and its age in cycles.
    bit          m_busy;
    int          m_age;
    logic        m_err;
    logic [31:0] m_cnt;
    logic [5:0]  e_stall;
    logic        e_fif, e_fex, e_req, e_we;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_eval();
        bit acc, mst, lu;
        acc   = mem_read_mem | mem_write_mem;
        e_req = m_busy | acc;
        e_we  = e_req & mem_write_mem;
        mst   = e_req && !dmem_ack && !(m_busy && m_age == T);
        lu    = mem_read_ex && rd_ex != 5'd0 &&
                ((rs1_used_id && rs1_id == rd_ex) || (rs2_used_id && rs2_id == rd_ex));
        e_fif = 1'b0; e_fex = 1'b0; e_stall = 6'd0;
        if (mst) e_stall = 6'b011111;
        else if (lu) begin e_stall = 6'b000111; e_fex = 1'b1; e_fif = branch_taken_ex; end
        else if (branch_taken_ex) begin e_fif = 1'b1; e_fex = 1'b1; end
        if (rst) begin e_stall = 6'd0; e_fif = 1'b0; e_fex = 1'b0; e_req = 1'b0; e_we = 1'b0; end
    endtask

    task automatic model_update();
        model_eval();
        if (rst) begin
            m_busy = 1'b0; m_age = 0; m_err = 1'b0; m_cnt = 32'd0;
        end else begin
            m_err = 1'b0;
            if (e_stall[0]) m_cnt = m_cnt + 32'd1;
            if (m_busy) begin
                if (dmem_ack) m_busy = 1'b0;
                else if (m_age == T) begin m_busy = 1'b0; m_err = 1'b1; end
                else m_age++;
            end else if ((mem_read_mem | mem_write_mem) && !dmem_ack) begin
                m_busy = 1'b1; m_age = 1;
            end
        end
    endtask

    task automatic model_check(input string tag);
        model_eval();
        chk({tag, ".stall"},     32'(stall),       32'(e_stall));
        chk({tag, ".flush_if"},  32'(flush_if_id), 32'(e_fif));
        chk({tag, ".flush_ex"},  32'(flush_id_ex), 32'(e_fex));
        chk({tag, ".req"},       32'(dmem_req),    32'(e_req));
        chk({tag, ".we"},        32'(dmem_we),     32'(e_we));
        chk({tag, ".mem_err"},   32'(mem_err),     32'(m_err));
        chk({tag, ".stall_cnt"}, stall_cnt,        m_cnt);
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_in();
        mem_read_mem = 1'b0; mem_write_mem = 1'b0; dmem_ack = 1'b0;
        mem_read_ex = 1'b0; rd_ex = 5'd0; rs1_id = 5'd0; rs2_id = 5'd0;
        rs1_used_id = 1'b0; rs2_used_id = 1'b0; branch_taken_ex = 1'b0;
    endtask

    typedef struct {
        logic       mrm, mwm, ack, mex;
        logic [4:0] rd, rs1, rs2;
        logic       u1, u2, br;
        logic [5:0] x_stall;
        logic       x_fif, x_fex, x_req, x_we;
    } vec_t;

    vec_t vecs[11];
    logic [31:0] c0;

    initial begin
        // mrm mwm ack mex rd rs1 rs2 u1 u2 br | stall fif fex req we
        vecs[0]  = '{0,0,0,1, 5, 5, 0,1,0,0, 6'b000111,0,1,0,0};
        vecs[1]  = '{0,0,0,1, 0, 0, 0,1,0,0, 6'b000000,0,0,0,0};
        vecs[2]  = '{0,0,0,1, 5, 5, 3,0,1,0, 6'b000000,0,0,0,0};
        vecs[3]  = '{0,0,0,1, 7, 1, 7,0,1,0, 6'b000111,0,1,0,0};
        vecs[4]  = '{0,0,0,0, 5, 5, 5,1,1,0, 6'b000000,0,0,0,0};
        vecs[5]  = '{0,0,0,0, 0, 0, 0,0,0,1, 6'b000000,1,1,0,0};
        vecs[6]  = '{0,0,0,1, 9, 9, 0,1,0,1, 6'b000111,1,1,0,0};
        vecs[7]  = '{0,0,0,1,31,31,31,1,1,0, 6'b000111,0,1,0,0};
        vecs[8]  = '{1,0,1,0, 0, 0, 0,0,0,0, 6'b000000,0,0,1,0};
        vecs[9]  = '{1,1,1,0, 0, 0, 0,0,0,0, 6'b000000,0,0,1,1};
        vecs[10] = '{0,1,1,0, 0, 0, 0,0,0,1, 6'b000000,1,1,1,1};

        // Reset with live inputs: combinational outputs must be held low.
        clear_in();
        m_busy = 1'b0; m_age = 0; m_err = 1'b0; m_cnt = 32'd0;
        rst = 1'b1; mem_write_mem = 1'b1; branch_taken_ex = 1'b1;
        mem_read_ex = 1'b1; rd_ex = 5'd3; rs1_id = 5'd3; rs1_used_id = 1'b1;
        #1;
        advance();
        @(negedge clk);
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.req",   32'(dmem_req), 32'd0);
        chk("rst.we",    32'(dmem_we), 32'd0);
        chk("rst.flush", 32'({flush_if_id, flush_id_ex}), 32'd0);
        chk("rst.cnt",   stall_cnt, 32'd0);
        chk("rst.err",   32'(mem_err), 32'd0);
        advance();
        rst = 1'b0; clear_in();

        // Single-cycle hazard / zero-wait access vectors.
        for (int i = 0; i < 11; i++) begin
            mem_read_mem = vecs[i].mrm; mem_write_mem = vecs[i].mwm; dmem_ack = vecs[i].ack;
            mem_read_ex = vecs[i].mex; rd_ex = vecs[i].rd; rs1_id = vecs[i].rs1;
            rs2_id = vecs[i].rs2; rs1_used_id = vecs[i].u1; rs2_used_id = vecs[i].u2;
            branch_taken_ex = vecs[i].br;
            @(negedge clk);
            chk($sformatf("vec%0d.stall", i),    32'(stall),       32'(vecs[i].x_stall));
            chk($sformatf("vec%0d.flush_if", i), 32'(flush_if_id), 32'(vecs[i].x_fif));
            chk($sformatf("vec%0d.flush_ex", i), 32'(flush_id_ex), 32'(vecs[i].x_fex));
            chk($sformatf("vec%0d.req", i),      32'(dmem_req),    32'(vecs[i].x_req));
            chk($sformatf("vec%0d.we", i),       32'(dmem_we),     32'(vecs[i].x_we));
            chk($sformatf("vec%0d.cnt", i),      stall_cnt,        m_cnt);
            advance();
        end
        clear_in();

        // Store acknowledged on the fourth cycle: three held cycles.
        c0 = m_cnt;
        mem_write_mem = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dmem_ack = (i == 3);
            @(negedge clk);
            chk($sformatf("st%0d.stall", i), 32'(stall), (i == 3) ? 32'h00 : 32'h1f);
            chk($sformatf("st%0d.we", i), 32'(dmem_we), 32'd1);
            model_check("st");
            advance();
        end
        clear_in();
        @(negedge clk);
        chk("st.cnt_delta", stall_cnt, c0 + 32'd3);
        chk("st.req_off", 32'(dmem_req), 32'd0);
        advance();

        // Branch during a memory wait is deferred until the ack.
        mem_read_mem = 1'b1; branch_taken_ex = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dmem_ack = (i == 2);
            @(negedge clk);
            chk($sformatf("br%0d.flush", i), 32'({flush_if_id, flush_id_ex}),
                (i == 2) ? 32'd3 : 32'd0);
            model_check("br");
            advance();
        end
        clear_in();

        // Never acknowledged: held T cycles, abandoned, single error pulse.
        c0 = m_cnt;
        mem_read_mem = 1'b1;
        for (int i = 0; i <= T; i++) begin
            @(negedge clk);
            chk($sformatf("to%0d.stall", i), 32'(stall), (i == T) ? 32'h00 : 32'h1f);
            chk($sformatf("to%0d.req", i), 32'(dmem_req), 32'd1);
            chk($sformatf("to%0d.err", i), 32'(mem_err), 32'd0);
            advance();
        end
        clear_in();
        @(negedge clk);
        chk("to.err_pulse", 32'(mem_err), 32'd1);
        chk("to.cnt_delta", stall_cnt, c0 + 32'(T));
        chk("to.idle_req", 32'(dmem_req), 32'd0);
        advance();
        @(negedge clk);
        chk("to.err_clear", 32'(mem_err), 32'd0);
        advance();

        // Reset in the middle of a wait abandons silently.
        mem_read_mem = 1'b1; mem_write_mem = 1'b1;
        advance();
        advance();
        rst = 1'b1;
        @(negedge clk);
        chk("rw.stall", 32'(stall), 32'd0);
        chk("rw.req", 32'(dmem_req), 32'd0);
        chk("rw.we", 32'(dmem_we), 32'd0);
        advance();
        rst = 1'b0; clear_in();
        for (int i = 0; i < T + 2; i++) begin
            @(negedge clk);
            chk($sformatf("rw%0d.err", i), 32'(mem_err), 32'd0);
            model_check("rw");
            advance();
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst             = ($urandom_range(0, 299) == 0);
            mem_read_mem    = ($urandom_range(0, 3) == 0);
            mem_write_mem   = ($urandom_range(0, 4) == 0);
            dmem_ack        = ($urandom_range(0, 3) == 0);
            mem_read_ex     = $urandom_range(0, 1) != 0;
            rd_ex           = 5'($urandom_range(0, 3));
            rs1_id          = 5'($urandom_range(0, 3));
            rs2_id          = 5'($urandom_range(0, 3));
            rs1_used_id     = $urandom_range(0, 1) != 0;
            rs2_used_id     = $urandom_range(0, 1) != 0;
            branch_taken_ex = ($urandom_range(0, 4) == 0);
            @(negedge clk);
            model_check("rnd");
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
